// File: rtl/contador_ocupacao_pkg.sv
// -----------------------------------------------------------------------------
// contador_ocupacao_pkg
// Constants shared by the gate FSM, the occupancy counter and the 7-segment
// decoder:
//   ST_A..ST_E : one-hot encodings of the gate FSM states
//                (A idle, B entry, C metal, D exit, E rotation-only)
//   SEG_BLANK  : all segments off on an active-low 7-segment display
//   is_onehot  : returns 1 when exactly one bit of a state word is set
// -----------------------------------------------------------------------------
package contador_ocupacao_pkg;

    localparam logic [4:0] ST_A = 5'b10000;
    localparam logic [4:0] ST_B = 5'b01000;
    localparam logic [4:0] ST_C = 5'b00100;
    localparam logic [4:0] ST_D = 5'b00010;
    localparam logic [4:0] ST_E = 5'b00001;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Clearing the lowest set bit leaves zero only for a single-bit word.
    function automatic logic is_onehot(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

endpackage

// File: rtl/contador_ocupacao_decod7seg.sv
// -----------------------------------------------------------------------------
// decod7seg
// Combinational BCD to active-low 7-segment decoder.
//   digito_i [3:0] : value to display (0..9; anything above shows blank)
//   seg_o    [6:0] : segments, bit 0 = a ... bit 6 = g, active low
// -----------------------------------------------------------------------------
module decod7seg
    import contador_ocupacao_pkg::*;
(
    input  logic [3:0] digito_i,
    output logic [6:0] seg_o
);

    always_comb begin
        // NOTE: every combinational output gets a value on every path (here via
        // the default arm); a missing path would infer a latch.
        unique case (digito_i)
            4'd0:    seg_o = 7'b1000000;
            4'd1:    seg_o = 7'b1111001;
            4'd2:    seg_o = 7'b0100100;
            4'd3:    seg_o = 7'b0110000;
            4'd4:    seg_o = 7'b0011001;
            4'd5:    seg_o = 7'b0010010;
            4'd6:    seg_o = 7'b0000010;
            4'd7:    seg_o = 7'b1111000;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0010000;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/contador_ocupacao.sv
// -----------------------------------------------------------------------------
// contador_ocupacao
// Counts people through a gate by watching the gate FSM's one-hot state,
// latches a metal-detector alarm and drives a 7-segment occupancy display
// that blinks while the alarm is active.
//   clock          : single clock, rising edge
//   reset          : synchronous, active high
//   estadoLed[4:0] : one-hot gate FSM state (A..E, see package)
//   ocupacao[3:0]  : current occupancy, 0..CAPACITY
//   cheio          : high while ocupacao == CAPACITY
//   alarme         : high while the metal alarm is latched
//   HEX0[6:0]      : active-low 7-segment digit (bit 0 = a, bit 6 = g)
// -----------------------------------------------------------------------------
module contador_ocupacao
    import contador_ocupacao_pkg::*;
#(
    parameter int CAPACITY  = 9,
    parameter int BLINK_DIV = 25_000_000
)(
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] estadoLed,
    output logic [3:0] ocupacao,
    output logic       cheio,
    output logic       alarme,
    output logic [6:0] HEX0
);

    localparam logic [3:0] CAP       = 4'(CAPACITY);
    localparam int         CNT_W     = (2 * BLINK_DIV > 1) ? $clog2(2 * BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * BLINK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BLINK_DIV);

    logic [4:0]       estado_ant_q, estado_ant_d;
    logic [3:0]       ocupacao_q,   ocupacao_d;
    logic             cheio_q,      cheio_d;
    logic             alarme_q,     alarme_d;
    logic [CNT_W-1:0] blink_q,      blink_d;

    logic       valido;
    logic       entrada;
    logic       saida;
    logic [6:0] seg_digito;

    assign valido  = is_onehot(estadoLed);
    assign entrada = valido && (estado_ant_q == ST_B) && (estadoLed == ST_A);
    assign saida   = valido && (estado_ant_q == ST_D) && (estadoLed == ST_A);

    always_comb begin
        estado_ant_d = estado_ant_q;
        ocupacao_d   = ocupacao_q;
        alarme_d     = alarme_q;

        // Malformed state words are dropped entirely, so the previous valid
        // state survives and a later A still pairs with it.
        if (valido) begin
            estado_ant_d = estadoLed;

            if (entrada && (ocupacao_q < CAP)) begin
                ocupacao_d = ocupacao_q + 4'd1;
            end else if (saida && (ocupacao_q != 4'd0)) begin
                ocupacao_d = ocupacao_q - 4'd1;
            end

            // Only an edge into C raises the alarm; holding C keeps it set.
            if ((estadoLed == ST_C) && (estado_ant_q != ST_C)) begin
                alarme_d = 1'b1;
            end else if (estadoLed == ST_A) begin
                alarme_d = 1'b0;
            end
        end

        // Held at zero while idle, so it always starts from 0 when alarme rises.
        if (!alarme_q) begin
            blink_d = '0;
        end else if (blink_q == CNT_LAST) begin
            blink_d = '0;
        end else begin
            blink_d = blink_q + 1'b1;
        end

        // Derived from the next count so the flag lands in the same cycle.
        cheio_d = (ocupacao_d == CAP);
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            estado_ant_q <= ST_A;
            ocupacao_q   <= 4'd0;
            cheio_q      <= 1'b0;
            alarme_q     <= 1'b0;
            blink_q      <= '0;
        end else begin
            estado_ant_q <= estado_ant_d;
            ocupacao_q   <= ocupacao_d;
            cheio_q      <= cheio_d;
            alarme_q     <= alarme_d;
            blink_q      <= blink_d;
        end
    end

    decod7seg u_decod7seg (
        .digito_i (ocupacao_q),
        .seg_o    (seg_digito)
    );

    // Digit for the first half of the blink period, blank for the second.
    assign HEX0     = (alarme_q && (blink_q >= CNT_HALF)) ? SEG_BLANK : seg_digito;
    assign ocupacao = ocupacao_q;
    assign cheio    = cheio_q;
    assign alarme   = alarme_q;

endmodule

// File: doc/contador_ocupacao.md
CONTADOR_OCUPACAO -- requirements
Module: contador_ocupacao

Interface
REQ-001 Parameter CAPACITY, default 9, is the maximum occupancy count, legal range 1..9.
REQ-002 Parameter BLINK_DIV, default 25_000_000, is the number of clock cycles per half-period of the alarm blink.
REQ-003 Port clock, input, 1 bit, is the single clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1 bit, is a synchronous, active-high reset.
REQ-005 Port estadoLed, input, 5 bits [4:0], is the one-hot gate-FSM state: 10000 idle (A), 01000 entry (B), 00100 metal (C), 00010 exit (D), 00001 rotation-only (E).
REQ-006 Port ocupacao, output, 4 bits, is the current occupancy count.
REQ-007 Port cheio, output, 1 bit, is high while ocupacao equals CAPACITY.
REQ-008 Port alarme, output, 1 bit, is high while the metal alarm is latched.
REQ-009 Port HEX0, output, 7 bits [6:0], drives an active-low 7-segment display, with bit 0 as segment a and bit 6 as segment g.

Function
REQ-010 The block SHALL register estadoLed into estado_ant every cycle in which the input is valid one-hot.
REQ-011 A non-one-hot estadoLed (zero or multiple bits set) SHALL be ignored: no count change, no alarm change, and estado_ant is held.
REQ-012 An entry event SHALL be the transition estado_ant=B to estadoLed=A.
REQ-013 An exit event SHALL be the transition estado_ant=D to estadoLed=A.
REQ-014 Any other transition, including B->D, D->B, B->C, E->A, or a held state, SHALL NOT change ocupacao.
REQ-015 On an entry event, ocupacao SHALL increment by 1, saturating at CAPACITY.
REQ-016 On an exit event, ocupacao SHALL decrement by 1, saturating at 0 (no wrap to 15).
REQ-017 An ocupacao update SHALL be visible on the cycle after the one in which the transition is sampled (latency 1).
REQ-018 cheio SHALL be registered and consistent with ocupacao in the same cycle.
REQ-019 alarme SHALL set on any valid transition from a state other than C into C.
REQ-020 alarme SHALL clear on a valid transition into A.
REQ-021 alarme SHALL have set and clear latency of 1 cycle.
REQ-022 While alarme=0, a blink counter SHALL be held at 0 and HEX0 SHALL show the decimal digit of ocupacao.
REQ-023 While alarme=1, a blink counter SHALL run modulo 2*BLINK_DIV, and HEX0 SHALL show the digit for the first BLINK_DIV counts and blank (1111111) for the rest.
REQ-024 The blink counter SHALL restart at 0 each time alarme rises.
REQ-025 The digit encoding SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-026 Any ocupacao value above 9 SHALL display blank; this value is unreachable, but the decoder SHALL be total.

Reset
REQ-027 On reset=1 at a clock edge, the block SHALL set ocupacao=0, cheio=0, alarme=0, blink counter=0, and estado_ant=10000.
REQ-028 HEX0 SHALL show 1000000 (digit 0) in the cycle after reset.
REQ-029 Reset SHALL take priority over any simultaneous event, including a reset asserted in the same cycle as an entry event, which SHALL leave ocupacao=0.
REQ-030 After reset deasserts, the first sampled transition SHALL be evaluated against estado_ant=A.

Structure
REQ-031 A shared package SHALL hold the five one-hot state constants (A..E) and the blank segment constant; the gate FSM SHALL share the state constants.
REQ-032 The 7-segment decode SHALL be a separate combinational sub-module, decod7seg (4-bit in, 7-bit active-low out), instantiated once.
REQ-033 The top-level projetoPessoal SHALL connect the gate FSM estadoLed output to this block and this block's HEX0 to the board HEX0.

Verification
REQ-034 The bench SHALL run with BLINK_DIV=4 and CAPACITY=9.
REQ-035 Scenario: reset, then apply A->B->A three times -> ocupacao=3, HEX0=0110000, one cycle after each return to A.
REQ-036 Scenario: from ocupacao=9, apply B->A -> ocupacao stays 9 and cheio=1; then apply D->A -> ocupacao=8 and cheio=0.
REQ-037 Scenario: from ocupacao=0, apply D->A -> ocupacao stays 0 (not 15); B->D->A -> ocupacao=0, no entry counted.
REQ-038 Scenario: with ocupacao=2, apply A->C -> alarme=1 next cycle; HEX0 alternates 0100100 / 1111111 every 4 cycles; C->A -> alarme=0 and HEX0 steady 0100100.
REQ-039 Scenario: estadoLed=01100 for 3 cycles between B and A -> ignored; the subsequent A is still an entry event and ocupacao increments by 1.
REQ-040 Scenario: reset asserted in the same cycle as a B->A transition at ocupacao=5 -> ocupacao=0, alarme=0, HEX0=1000000.
